// File: rtl/controlpath_param.sv
// Parametrised control path: decodes one instruction per cycle into ALU, register-file, memory and stack controls.
// Latency: every output is registered, so a decode sampled at edge N is visible after edge N; mul/div ops take MC_LAT cycles.
// Flow: no handshake; the STOPPED and MULTI states hold the PC by keeping program_counter_increment low. Optional macro: STACK_OPS_EN.
module controlpath_param #(
   parameter int DATA_W      = 16,
   parameter int REG_W       = 4,
   parameter int MC_LAT      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   user_clock,
   input  logic [4+3*REG_W-1:0]   current_instruction,
   input  logic [DATA_W-1:0]      switches,
   input  logic [2**REG_W-1:0]    zeroflag,
   input  logic [2**REG_W-1:0]    signflag,
   output logic                   program_counter_increment,
   output logic [3:0]             alu_op,
   output logic [DATA_W-1:0]      alu_a_altern,
   output logic [DATA_W-1:0]      alu_b_altern,
   output logic [REG_W-1:0]       alu_a_select,
   output logic [REG_W-1:0]       alu_b_select,
   output logic                   alu_a_source,
   output logic                   alu_b_source,
   output logic [REG_W-1:0]       alu_out_select,
   output logic [1:0]             alu_load_src,
   output logic                   alu_store_to_mem,
   output logic                   alu_store_to_stk,
   output logic                   halted,
   output logic                   busy
);

   localparam int CW = $clog2(MC_LAT + 1);

   typedef enum logic [1:0] {RUN, STOPPED, MULTI} state_t;

   typedef struct packed {
      logic              pc_inc;
      logic [3:0]        op;
      logic [DATA_W-1:0] a_alt;
      logic [DATA_W-1:0] b_alt;
      logic [REG_W-1:0]  a_sel;
      logic [REG_W-1:0]  b_sel;
      logic              a_src;
      logic              b_src;
      logic [REG_W-1:0]  out_sel;
      logic [1:0]        load;
      logic              mem;
   } ctl_t;

   state_t              state_q, state_d;
   ctl_t                ctl_q, ctl_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                uclk_prev_q;
   logic                uclk_rise;

   logic [3:0]          op;
   logic [REG_W-1:0]    f1, f2, f3;
   logic [1:0]          jmode;
   logic                jcond;

   assign {op, f1, f2, f3} = current_instruction;
   assign jmode     = f1[REG_W-1:REG_W-2];
   assign uclk_rise = sync_q[SYNC_STAGES-1] & ~uclk_prev_q;

   // Jump condition selected by the two top bits of f1
   always_comb begin
      jcond = 1'b1;
      case (jmode)
         2'b00: jcond = 1'b1;
         2'b01: jcond = ~zeroflag[f2];
         2'b10: jcond = zeroflag[f2];
         2'b11: jcond = signflag[f2];
         default: jcond = 1'b1;
      endcase
   end

`ifdef STACK_OPS_EN
   logic stk_q, stk_d;
`endif

   // Next-state and next-output logic for the RUN / STOPPED / MULTI FSM
   always_comb begin
      state_d = state_q;
      ctl_d   = ctl_q;
      cnt_d   = cnt_q;
`ifdef STACK_OPS_EN
      stk_d   = 1'b0;
`endif
      case (state_q)
         RUN: begin
            ctl_d        = '0;
            ctl_d.pc_inc = 1'b1;
            case (op)
               4'h0: begin
                  if (f1 == REG_W'(1)) begin          // SWTR
                     ctl_d.a_src   = 1'b1;
                     ctl_d.a_alt   = switches;
                     ctl_d.b_sel   = f3;
                     ctl_d.out_sel = f3;
                     ctl_d.load    = 2'b01;
                  end else if (f1 == REG_W'(3)) begin // SWCL
                     state_d = STOPPED;
                  end else if (f1 == REG_W'(12)) begin // WMEM
                     ctl_d.a_sel   = f2;
                     ctl_d.b_sel   = f3;
                     ctl_d.out_sel = f2;
                     ctl_d.mem     = 1'b1;
`ifdef STACK_OPS_EN
                  end else if (f1 == REG_W'(13)) begin // PUSH
                     ctl_d.a_sel = f3;
                     stk_d       = 1'b1;
                  end else if (f1 == REG_W'(14)) begin // POP
                     ctl_d.out_sel = f3;
                     ctl_d.load    = 2'b10;
`endif
                  end
               end
               4'h3, 4'h4, 4'h7, 4'h8: begin
                  // Multi-cycle ops: fields latched now, result loaded on the last cycle
                  ctl_d.op      = op;
                  ctl_d.a_sel   = f1;
                  ctl_d.b_sel   = f2;
                  ctl_d.out_sel = f3;
                  ctl_d.pc_inc  = 1'b0;
                  cnt_d         = CW'(1);
                  state_d       = MULTI;
               end
               4'hE: begin                             // INCR
                  ctl_d.op      = 4'h1;
                  ctl_d.a_sel   = f3;
                  ctl_d.b_src   = 1'b1;
                  ctl_d.b_alt   = DATA_W'(f2);
                  ctl_d.out_sel = f3;
                  ctl_d.load    = 2'b01;
               end
               4'hF: begin                             // JUMP
                  if (jcond) begin
                     ctl_d.a_sel  = f3;
                     ctl_d.load   = 2'b01;
                     ctl_d.pc_inc = 1'b0;
                  end
               end
               default: begin
                  ctl_d.op      = op;
                  ctl_d.a_sel   = f1;
                  ctl_d.b_sel   = f2;
                  ctl_d.out_sel = f3;
                  ctl_d.load    = 2'b01;
               end
            endcase
         end
         MULTI: begin
            if (cnt_q == CW'(MC_LAT - 1)) begin
               ctl_d.load   = 2'b01;
               ctl_d.pc_inc = 1'b1;
               state_d      = RUN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOPPED: begin
            ctl_d.load   = 2'b00;
            ctl_d.mem    = 1'b0;
            ctl_d.pc_inc = 1'b0;
            if (uclk_rise) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // State, output registers and user_clock synchroniser
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         ctl_q       <= '0;
         cnt_q       <= '0;
         sync_q      <= '1;
         uclk_prev_q <= 1'b1;
`ifdef STACK_OPS_EN
         stk_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ctl_q       <= ctl_d;
         cnt_q       <= cnt_d;
         sync_q      <= {sync_q[SYNC_STAGES-2:0], user_clock};
         uclk_prev_q <= sync_q[SYNC_STAGES-1];
`ifdef STACK_OPS_EN
         stk_q       <= stk_d;
`endif
      end
   end

`ifdef STACK_OPS_EN
   assign alu_store_to_stk = stk_q;
`else
   assign alu_store_to_stk = 1'b0;
`endif

   assign program_counter_increment = ctl_q.pc_inc;
   assign alu_op           = ctl_q.op;
   assign alu_a_altern     = ctl_q.a_alt;
   assign alu_b_altern     = ctl_q.b_alt;
   assign alu_a_select     = ctl_q.a_sel;
   assign alu_b_select     = ctl_q.b_sel;
   assign alu_a_source     = ctl_q.a_src;
   assign alu_b_source     = ctl_q.b_src;
   assign alu_out_select   = ctl_q.out_sel;
   assign alu_load_src     = ctl_q.load;
   assign alu_store_to_mem = ctl_q.mem;
   assign halted           = (state_q == STOPPED);
   assign busy             = (state_q == MULTI);

endmodule

// File: tb/tb_controlpath_param.sv
// Bench for controlpath_param: expected output records are queued as each instruction is driven
// and popped/compared one cycle later, sampled 1 ns after the rising edge.
// Covers reset, ALU/INCR/JUMP/WMEM decode, STOP/resume, multi-cycle ops, async reset and PUSH.
module tb_controlpath_param;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int MC_LAT = 4;
   localparam int SYNC_STAGES = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        user_clock = 1'b0;
   logic [15:0] current_instruction = '0;
   logic [15:0] switches = '0;
   logic [15:0] zeroflag = '0;
   logic [15:0] signflag = '0;
   logic        program_counter_increment;
   logic [3:0]  alu_op;
   logic [15:0] alu_a_altern, alu_b_altern;
   logic [3:0]  alu_a_select, alu_b_select, alu_out_select;
   logic        alu_a_source, alu_b_source;
   logic [1:0]  alu_load_src;
   logic        alu_store_to_mem, alu_store_to_stk, halted, busy;

   controlpath_param #(.DATA_W(DATA_W), .REG_W(REG_W), .MC_LAT(MC_LAT), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clock(clock), .reset(reset), .user_clock(user_clock),
      .current_instruction(current_instruction), .switches(switches),
      .zeroflag(zeroflag), .signflag(signflag),
      .program_counter_increment(program_counter_increment),
      .alu_op(alu_op), .alu_a_altern(alu_a_altern), .alu_b_altern(alu_b_altern),
      .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
      .alu_a_source(alu_a_source), .alu_b_source(alu_b_source),
      .alu_out_select(alu_out_select), .alu_load_src(alu_load_src),
      .alu_store_to_mem(alu_store_to_mem), .alu_store_to_stk(alu_store_to_stk),
      .halted(halted), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        pc;
      logic [3:0]  op;
      logic [15:0] a_alt, b_alt;
      logic [3:0]  a_sel, b_sel, out;
      logic        a_src, b_src;
      logic [1:0]  ld;
      logic        mem, stk, hlt, bsy;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   function automatic exp_t zrec();
      exp_t e;
      e.pc = 0; e.op = 0; e.a_alt = 0; e.b_alt = 0; e.a_sel = 0; e.b_sel = 0; e.out = 0;
      e.a_src = 0; e.b_src = 0; e.ld = 0; e.mem = 0; e.stk = 0; e.hlt = 0; e.bsy = 0;
      return e;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Pop the oldest expectation and compare every output against it
   task automatic sb_check(string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".pc_inc"}, program_counter_increment, e.pc);
         chk({tag, ".alu_op"}, alu_op, e.op);
         chk({tag, ".a_alt"},  alu_a_altern, e.a_alt);
         chk({tag, ".b_alt"},  alu_b_altern, e.b_alt);
         chk({tag, ".a_sel"},  alu_a_select, e.a_sel);
         chk({tag, ".b_sel"},  alu_b_select, e.b_sel);
         chk({tag, ".a_src"},  alu_a_source, e.a_src);
         chk({tag, ".b_src"},  alu_b_source, e.b_src);
         chk({tag, ".out"},    alu_out_select, e.out);
         chk({tag, ".load"},   alu_load_src, e.ld);
         chk({tag, ".mem"},    alu_store_to_mem, e.mem);
         chk({tag, ".stk"},    alu_store_to_stk, e.stk);
         chk({tag, ".halted"}, halted, e.hlt);
         chk({tag, ".busy"},   busy, e.bsy);
      end
   endtask

   task automatic issue(logic [15:0] ins, exp_t e, string tag);
      current_instruction = ins;
      exp_q.push_back(e);
      step();
      sb_check(tag);
   endtask

   initial begin
      exp_t e;
      int   cyc;

      // Reset state
      #2;
      exp_q.push_back(zrec());
      sb_check("reset");
      step();
      reset = 1'b0;

      // INCR 0 6 6
      e = zrec(); e.op = 1; e.a_sel = 6; e.b_src = 1; e.b_alt = 16'h6; e.out = 6; e.ld = 1; e.pc = 1;
      issue(16'hE066, e, "incr");

      // Generic ALU op 2 A B C
      e = zrec(); e.op = 2; e.a_sel = 4'hA; e.b_sel = 4'hB; e.out = 4'hC; e.ld = 1; e.pc = 1;
      issue(16'h2ABC, e, "alu2");

      // SWCL then SWTR 0 5 while stopped
      switches = 16'h1567;
      e = zrec(); e.pc = 1; e.hlt = 1;
      issue(16'h0300, e, "swcl");
      e = zrec(); e.hlt = 1;
      issue(16'h0105, e, "stopped1");
      issue(16'h0105, e, "stopped2");

      // Resume via user_clock rising edge through the synchroniser
      user_clock = 1'b1;
      cyc = 0;
      while (halted && cyc < 10) begin
         step();
         cyc++;
      end
      chk("resume_latency", cyc, SYNC_STAGES + 1);
      e = zrec();
      exp_q.push_back(e);
      sb_check("resumed_hold");
      e = zrec(); e.a_src = 1; e.a_alt = 16'h1567; e.b_sel = 5; e.out = 5; e.ld = 1; e.pc = 1;
      issue(16'h0105, e, "swtr");
      user_clock = 1'b0;

      // IMUL 2 3 4: three busy cycles then completion
      e = zrec(); e.op = 3; e.a_sel = 2; e.b_sel = 3; e.out = 4; e.bsy = 1;
      issue(16'h3234, e, "imul_c1");
      issue(16'h0000, e, "imul_c2");
      issue(16'h0000, e, "imul_c3");
      e.bsy = 0; e.ld = 1; e.pc = 1;
      issue(16'h0000, e, "imul_done");

      // JUMP mode 01 on zeroflag[5], target register 7
      zeroflag = '0;
      e = zrec(); e.a_sel = 7; e.ld = 1;
      issue(16'hF457, e, "jmp_nz_taken");
      zeroflag[5] = 1'b1;
      e = zrec(); e.pc = 1;
      issue(16'hF457, e, "jmp_nz_not");

      // JUMP mode 11 on signflag[2], target register 9
      signflag[2] = 1'b1;
      e = zrec(); e.a_sel = 9; e.ld = 1;
      issue(16'hFC29, e, "jmp_sign_taken");
      signflag[2] = 1'b0;
      e = zrec(); e.pc = 1;
      issue(16'hFC29, e, "jmp_sign_not");

      // WMEM 5 6
      e = zrec(); e.a_sel = 5; e.b_sel = 6; e.out = 5; e.mem = 1; e.pc = 1;
      issue(16'h0C56, e, "wmem");

      // PUSH 0 3
      e = zrec(); e.pc = 1;
`ifdef STACK_OPS_EN
      e.a_sel = 3; e.stk = 1;
`endif
      issue(16'h0D03, e, "push");

      // Async reset in the middle of IDIV
      e = zrec(); e.op = 4; e.a_sel = 1; e.b_sel = 2; e.out = 3; e.bsy = 1;
      issue(16'h4123, e, "idiv_c1");
      #2;
      reset = 1'b1;
      #1;
      exp_q.push_back(zrec());
      sb_check("idiv_abort");
      reset = 1'b0;
      e = zrec(); e.pc = 1;
      issue(16'h0000, e, "nop_after_abort");

      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/controlpath_param.md
Name: controlpath_param

Overview:
- Parametrised successor to the single-width control path.
- Decodes one instruction per cycle into ALU, register-file, memory and stack control.
- Generalised instruction, data and register widths.
- Adds a stop/resume FSM driven by a synchronised user clock, multi-cycle stalls for mul/div opcodes, and a sign-flag jump mode.
- Sits between the instruction memory/PC and the datapath.

Parameters:
- DATA_W, 16: width of switches and alu_*_altern; must be ≥ 3*REG_W+4.
- REG_W, 4: register-select width; register count NREG = 2**REG_W; instruction width IW = 4+3*REG_W.
- MC_LAT, 4: total cycles spent on IMUL/IDIV/FMUL/FDIV (opcodes 3,4,7,8); must be ≥ 2.
- SYNC_STAGES, 2: flip-flop stages synchronising user_clock.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- user_clock  in  1  asynchronous user step/resume input
- current_instruction  in  IW  {op[3:0], f1, f2, f3}; each field is REG_W bits
- switches  in  DATA_W  user switch value
- zeroflag  in  NREG  per-register zero flag
- signflag  in  NREG  per-register sign flag
- program_counter_increment  out  1  advance the PC this cycle
- alu_op  out  4  ALU operation code
- alu_a_altern  out  DATA_W  alternate A operand
- alu_b_altern  out  DATA_W  alternate B operand
- alu_a_select  out  REG_W  A operand register select
- alu_b_select  out  REG_W  B operand register select
- alu_a_source  out  1  1 = A taken from altern
- alu_b_source  out  1  1 = B taken from altern
- alu_out_select  out  REG_W  destination register
- alu_load_src  out  2  00 none, 01 ALU result, 10 stack
- alu_store_to_mem  out  1  memory write strobe
- alu_store_to_stk  out  1  stack write strobe
- halted  out  1  FSM is in STOPPED
- busy  out  1  FSM is in MULTI

Behaviour:
- Reset: all outputs 0; FSM enters RUN; user_clock synchroniser cleared to 1.
- All outputs are registered. Decode of current_instruction sampled at edge N is visible after edge N.
- FSM states: RUN, STOPPED, MULTI.
- RUN decode table:
  - op 0 (NULL), subop = f1:
    - 0 NOP: everything 0 except pc_inc=1.
    - 1 SWTR: alu_op=0 (LEFT); a_source=1; a_altern=switches; b_select=f3; out=f3; load=01.
    - 3 SWCL: all strobes 0, pc_inc=1; next state STOPPED.
    - C WMEM: a_select=f2; b_select=f3; out=f2; store_to_mem=1; load=00.
    - Other subops: same as NOP.
  - op 1–B except 3,4,7,8: alu_op=op; a_select=f1; b_select=f2; out=f3; load=01.
  - op 3,4,7,8: same fields as the line above; next state MULTI.
  - op C (ISHL), op D (UNAR): same as generic ALU.
  - op E (INCR): alu_op=1; a_select=f3; b_source=1; b_altern=zero-extended f2; out=f3; load=01.
  - op F (JUMP): mode = f1[REG_W-1:REG_W-2]; cond bit = 00 always, 01 !zeroflag[f2], 10 zeroflag[f2], 11 signflag[f2].
    - Taken: alu_op=0; a_select=f3; out=0 (PC register); load=01; pc_inc=0.
    - Not taken: load=00; pc_inc=1.
- pc_inc=1 for every completed non-jump instruction.
- MULTI:
  - ALU fields are held from entry.
  - load=00 and pc_inc=0 for the first MC_LAT-1 cycles.
  - On cycle MC_LAT: load=01 and pc_inc=1, then return to RUN.
  - current_instruction is ignored while in MULTI.
- STOPPED:
  - load=00, stores=0, pc_inc=0; other fields hold their last values.
  - Resume on a rising edge (0→1) of synchronised user_clock. The instruction present at the edge after detection is decoded as in RUN.
  - A user_clock edge seen in RUN or MULTI is ignored.
- Simultaneous events:
  - Reset asserted during MULTI or STOPPED aborts immediately; no strobe is emitted.
  - SWCL decoded in the same cycle as a user_clock edge still stops; that edge is not counted.
- altern and select fields are zero-extended to their port widths.

Optional Feature:
- STACK_OPS_EN defined:
  - NULL subop D PUSH: a_select=f3; store_to_stk=1; pc_inc=1.
  - NULL subop E POP: out=f3; load=10; pc_inc=1.
- Undefined: subops D and E behave as NOP, and alu_store_to_stk is tied to 0.

Test Plan:
- Reset, then INCR 0 6 6 → next cycle: alu_op=1, out=6, load=01, a_source=0, b_source=1, b_altern=6, no stores.
- SWCL, switches=0x1567, then SWTR 0 5 while stopped → load=00, halted=1. After a user_clock low→high pulse plus the sync delay: load=01, a_altern=0x1567, b_select=5, out=5.
- IMUL 2 3 4 with MC_LAT=4 → busy=1 for 3 cycles with load=00; on the 4th cycle load=01, pc_inc=1, out=4.
- JUMP 01 5 7:
  - zeroflag[5]=0 → load=01, out=0, a_select=7, pc_inc=0.
  - zeroflag[5]=1 → load=00, pc_inc=1.
- WMEM 5 6 → store_to_mem=1, load=00, a_select=5, b_select=6. Reset asserted mid-IDIV → all outputs 0 asynchronously, FSM back in RUN.
- With STACK_OPS_EN: PUSH 0 3 → store_to_stk=1, a_select=3. Without STACK_OPS_EN, the same PUSH → store_to_stk=0, load=00.
